// File: rtl/seven_seg_decoder.sv
// Recovers the number shown on a multiplexed, active-low 8-digit seven-segment display
// by watching its anode/cathode lines, then converts each completed frame to binary.
module seven_seg_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int FRAME_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  anode,
  input  logic [7:0]  cathode,
  output logic [26:0] number,
  output logic        valid,
  output logic [7:0]  digit_mask,
  output logic        error,
  output logic        overrun
);

  localparam int TW = $clog2(FRAME_TIMEOUT + 1);

  typedef enum logic {COLLECT, CONVERT} state_t;
  state_t state, state_next;

  logic [7:0]    anode_q, cathode_q, last_anode, last_cathode;
  logic [7:0]    stab_cnt;
  logic [TW-1:0] idle_cnt;
  logic [3:0]    collect [8];
  logic [7:0]    seen;
  logic          frame_err;
  logic [3:0]    snap [8];
  logic [7:0]    snap_seen;
  logic          snap_err;
  logic [26:0]   acc, acc_step;
  logic [2:0]    step, conv_idx;

  logic       pair_same, accept, acc_blank, acc_multi, digit, pat_ok;
  logic       repeat_hit, timeout, frame_end, new_err, conv_done;
  logic [2:0] acc_idx;
  logic [3:0] dec_val, snap_sel;

  // Returns {pattern_ok, value}; DP is excluded by the caller.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'h40:   return {1'b1, 4'd0};
      7'h79:   return {1'b1, 4'd1};
      7'h24:   return {1'b1, 4'd2};
      7'h30:   return {1'b1, 4'd3};
      7'h19:   return {1'b1, 4'd4};
      7'h12:   return {1'b1, 4'd5};
      7'h02:   return {1'b1, 4'd6};
      7'h78:   return {1'b1, 4'd7};
      7'h00:   return {1'b1, 4'd8};
      7'h10:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pair_same = (anode_q == last_anode) && (cathode_q == last_cathode);
    accept    = pair_same && (stab_cnt == 8'(STABLE_CYCLES - 1));
    acc_blank = (anode_q == 8'hFF);
    acc_multi = ($countones(~anode_q) > 1);
    acc_idx   = '0;
    for (int i = 0; i < 8; i++) begin
      if (!anode_q[i]) acc_idx = 3'(i);
    end
    {pat_ok, dec_val} = decode_seg(cathode_q[6:0]);
    digit      = accept && !acc_blank && !acc_multi;
    new_err    = accept && !acc_blank && (acc_multi || !pat_ok);
    repeat_hit = digit && seen[acc_idx];
    timeout    = (seen != 8'd0) && (idle_cnt == TW'(FRAME_TIMEOUT));
    frame_end  = repeat_hit || timeout;

    conv_idx  = 3'd7 - step;
    snap_sel  = snap_seen[conv_idx] ? snap[conv_idx] : 4'd0;
    acc_step  = acc * 27'd10 + {23'd0, snap_sel};
    conv_done = (state == CONVERT) && (step == 3'd7);

    state_next = state;
    case (state)
      COLLECT: if (frame_end) state_next = CONVERT;
      CONVERT: if (conv_done) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= COLLECT;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      anode_q      <= 8'hFF;
      cathode_q    <= 8'hFF;
      last_anode   <= 8'hFF;
      last_cathode <= 8'hFF;
      stab_cnt     <= '0;
      idle_cnt     <= '0;
      seen         <= '0;
      frame_err    <= 1'b0;
      snap_seen    <= '0;
      snap_err     <= 1'b0;
      acc          <= '0;
      step         <= '0;
      number       <= '0;
      valid        <= 1'b0;
      digit_mask   <= '0;
      error        <= 1'b0;
      overrun      <= 1'b0;
      // NOTE: the digit stores are small and must read as zero after reset, so they are reset explicitly.
      for (int i = 0; i < 8; i++) begin
        collect[i] <= '0;
        snap[i]    <= '0;
      end
    end else begin
      anode_q      <= anode;
      cathode_q    <= cathode;
      last_anode   <= anode_q;
      last_cathode <= cathode_q;
      valid        <= 1'b0;
      overrun      <= 1'b0;

      if (!pair_same)                           stab_cnt <= 8'd1;
      else if (stab_cnt != 8'(STABLE_CYCLES))   stab_cnt <= stab_cnt + 8'd1;

      if (frame_end) begin
        if (state == COLLECT) begin
          snap      <= collect;
          snap_seen <= seen;
          snap_err  <= frame_err;
          acc       <= '0;
          step      <= '0;
        end else begin
          overrun <= 1'b1;
        end
        // The repeating digit (if any) opens the next frame.
        for (int i = 0; i < 8; i++) collect[i] <= '0;
        seen      <= '0;
        frame_err <= new_err;
        idle_cnt  <= '0;
        if (digit) begin
          seen[acc_idx]    <= 1'b1;
          collect[acc_idx] <= dec_val;
          idle_cnt         <= TW'(1);
        end
      end else if (accept && !acc_blank) begin
        idle_cnt <= TW'(1);
        if (new_err) frame_err <= 1'b1;
        if (digit) begin
          seen[acc_idx]    <= 1'b1;
          collect[acc_idx] <= dec_val;
        end
      end else if ((seen != 8'd0) && (idle_cnt != TW'(FRAME_TIMEOUT))) begin
        idle_cnt <= idle_cnt + TW'(1);
      end

      if (state == CONVERT) begin
        acc  <= acc_step;
        step <= step + 3'd1;
        if (conv_done) begin
          number     <= acc_step;
          digit_mask <= snap_seen;
          error      <= snap_err;
          valid      <= 1'b1;
        end
      end
    end
  end

endmodule
